// File: rtl/bus_arbiter_if.sv
// Signal bundle between the two requesters, the bus fabric and the arbiter.
// The arbiter masters the read/write/data buses, so it takes the master view.
interface bus_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  enable;
  logic                  req0_valid;
  logic                  req0_ready;
  logic [1:0]            req0_mode;
  logic [ADDR_WIDTH-1:0] req0_src;
  logic [ADDR_WIDTH-1:0] req0_dst;
  logic [DATA_WIDTH-1:0] req0_imm;
  logic                  req1_valid;
  logic                  req1_ready;
  logic [1:0]            req1_mode;
  logic [ADDR_WIDTH-1:0] req1_src;
  logic [ADDR_WIDTH-1:0] req1_dst;
  logic [DATA_WIDTH-1:0] req1_imm;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic                  read_en;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic                  write_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_out_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rsp_valid;
  logic                  rsp_id;
  logic [DATA_WIDTH-1:0] rsp_data;

  modport master (
    input  enable,
    input  req0_valid, req0_mode, req0_src, req0_dst, req0_imm,
    input  req1_valid, req1_mode, req1_src, req1_dst, req1_imm,
    output req0_ready, req1_ready,
    output read_addr, read_en, write_addr, write_en, data_out, data_out_en,
    input  data_in,
    output rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    output enable,
    output req0_valid, req0_mode, req0_src, req0_dst, req0_imm,
    output req1_valid, req1_mode, req1_src, req1_dst, req1_imm,
    input  req0_ready, req1_ready,
    input  read_addr, read_en, write_addr, write_en, data_out, data_out_en,
    output data_in,
    input  rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for two bus masters; sequences the read and write
// phases of one granted transfer descriptor at a time and returns a response.
//
// state | meaning
// IDLE  | arbitrate; ready pulse and descriptor latch on grant
// READ  | read_en asserted for 1+READ_WAIT cycles, data_in captured at the end
// WRITE | single write strobe; imm driven, or source kept on the bus for a move
// RESP  | one-cycle rsp_valid pulse
module bus_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int READ_WAIT  = 0
) (
  input logic clk,
  input logic reset,
  bus_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t                state, state_nxt;
  logic                  last_grant;
  logic                  cur_id;
  logic [1:0]            cur_mode;
  logic [ADDR_WIDTH-1:0] cur_src;
  logic [ADDR_WIDTH-1:0] cur_dst;
  logic [DATA_WIDTH-1:0] cur_imm;
  logic [DATA_WIDTH-1:0] cur_rdata;
  logic [2:0]            wait_cnt;
  logic                  grant0, grant1, grant;
  logic [1:0]            grant_mode;

  // Grants are gated by reset so both ready pulses stay low while it is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset && state == IDLE && bus.enable) begin
      if (bus.req0_valid && (!bus.req1_valid || last_grant))
        grant0 = 1'b1;
      else if (bus.req1_valid)
        grant1 = 1'b1;
    end
  end

  assign grant      = grant0 | grant1;
  assign grant_mode = grant1 ? bus.req1_mode : bus.req0_mode;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = grant_mode[0] ? READ : (grant_mode[1] ? WRITE : RESP);
      READ:    if (wait_cnt == 3'd0) state_nxt = cur_mode[1] ? WRITE : RESP;
      WRITE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b1;
      cur_id     <= 1'b0;
      cur_mode   <= 2'b00;
      cur_src    <= '0;
      cur_dst    <= '0;
      cur_imm    <= '0;
      cur_rdata  <= '0;
      wait_cnt   <= 3'd0;
    end else if (grant) begin
      last_grant <= grant1;
      cur_id     <= grant1;
      cur_mode   <= grant_mode;
      cur_src    <= grant1 ? bus.req1_src : bus.req0_src;
      cur_dst    <= grant1 ? bus.req1_dst : bus.req0_dst;
      cur_imm    <= grant1 ? bus.req1_imm : bus.req0_imm;
      cur_rdata  <= '0;
      wait_cnt   <= 3'(READ_WAIT);
    end else if (state == READ) begin
      if (wait_cnt == 3'd0) cur_rdata <= bus.data_in;
      else                  wait_cnt  <= wait_cnt - 3'd1;
    end
  end

  // A move keeps the source slave driving data_bus through the write strobe.
  assign bus.req0_ready  = grant0;
  assign bus.req1_ready  = grant1;
  assign bus.read_en     = (state == READ) || (state == WRITE && cur_mode[0]);
  assign bus.read_addr   = cur_src;
  assign bus.write_en    = (state == WRITE);
  assign bus.write_addr  = cur_dst;
  assign bus.data_out_en = (state == WRITE) && !cur_mode[0];
  assign bus.data_out    = cur_imm;
  assign bus.rsp_valid   = (state == RESP);
  assign bus.rsp_id      = cur_id;
  assign bus.rsp_data    = cur_rdata;
endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboarded bench for bus_arbiter: an ALU/RAM slave model on the fabric,
// directed transfers, and a slow-slave instance with READ_WAIT=2.
module tb_bus_arbiter;
  localparam logic [15:0] ALU_1     = 16'h0001;
  localparam logic [15:0] ALU_2     = 16'h0002;
  localparam logic [15:0] ALU_ADD   = 16'h0003;
  localparam logic [15:0] RAM_START = 16'h0100;

  typedef struct {
    logic        id;
    logic [15:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  exp_t q1[$];
  exp_t q2[$];

  logic [15:0] alu_a = 16'h0;
  logic [15:0] alu_b = 16'h0;
  logic [15:0] ram [16];
  logic [15:0] data_bus1;
  int          rd_age = 0;

  bus_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus1 ();
  bus_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus2 ();

  bus_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .READ_WAIT(0)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.master));
  bus_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .READ_WAIT(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.master));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] slave_rd(input logic [15:0] a);
    if (a == ALU_1) return alu_a;
    if (a == ALU_2) return alu_b;
    if (a == ALU_ADD) return alu_a + alu_b;
    if ((a & 16'hfff0) == RAM_START) return ram[a[3:0]];
    return 16'h0;
  endfunction

  always_comb begin
    data_bus1 = 16'h0;
    if (bus1.data_out_en) data_bus1 = bus1.data_out;
    else if (bus1.read_en) data_bus1 = slave_rd(bus1.read_addr);
  end
  assign bus1.data_in = data_bus1;

  always @(posedge clk) begin
    if (bus1.write_en) begin
      if (bus1.write_addr == ALU_1) alu_a <= data_bus1;
      else if (bus1.write_addr == ALU_2) alu_b <= data_bus1;
      else if ((bus1.write_addr & 16'hfff0) == RAM_START) ram[bus1.write_addr[3:0]] <= data_bus1;
    end
  end

  // Slow slave: its data is only valid in the third consecutive read cycle.
  always @(posedge clk) rd_age <= bus2.read_en ? rd_age + 1 : 0;
  assign bus2.data_in = (bus2.read_en && rd_age == 2) ? 16'd8 : 16'hdead;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus1.rsp_valid) begin
      if (q1.size() == 0) check("rsp1_unexpected", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        check("rsp1_id", 32'(bus1.rsp_id), 32'(e.id));
        check("rsp1_data", 32'(bus1.rsp_data), 32'(e.data));
        check("rsp1_latency", 32'(cyc), 32'(e.due));
      end
    end
    if (bus2.rsp_valid) begin
      if (q2.size() == 0) check("rsp2_unexpected", 32'd1, 32'd0);
      else begin
        e = q2.pop_front();
        check("rsp2_id", 32'(bus2.rsp_id), 32'(e.id));
        check("rsp2_data", 32'(bus2.rsp_data), 32'(e.data));
        check("rsp2_latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic push1(input logic id, input logic [15:0] data, input int lat);
    exp_t e;
    e.id = id; e.data = data; e.due = cyc + lat;
    q1.push_back(e);
  endtask

  // Issue one descriptor on dut1 and return one cycle after acceptance (#1 past the edge).
  task automatic send(input logic id, input logic [1:0] mode, input logic [15:0] src,
                      input logic [15:0] dst, input logic [15:0] imm,
                      input logic [15:0] exp_data, input int lat, input logic want_rsp);
    logic got;
    if (id) begin
      bus1.req1_mode = mode; bus1.req1_src = src; bus1.req1_dst = dst; bus1.req1_imm = imm;
      bus1.req1_valid = 1'b1;
    end else begin
      bus1.req0_mode = mode; bus1.req0_src = src; bus1.req0_dst = dst; bus1.req0_imm = imm;
      bus1.req0_valid = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = id ? bus1.req1_ready : bus1.req0_ready;
    end
    check("accept", 32'(got), 32'd1);
    if (got && want_rsp) push1(id, exp_data, lat);
    @(posedge clk); #1;
    bus1.req0_valid = 1'b0;
    bus1.req1_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && (q1.size() != 0 || q2.size() != 0); i++) @(posedge clk);
    check("drain", 32'(q1.size() + q2.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int acc [3];
    logic got;
    int stuck;
    bus1.enable = 1'b1; bus2.enable = 1'b1;
    bus1.req0_valid = 0; bus1.req1_valid = 0; bus2.req0_valid = 0; bus2.req1_valid = 0;
    bus1.req0_mode = 0; bus1.req0_src = 0; bus1.req0_dst = 0; bus1.req0_imm = 0;
    bus1.req1_mode = 0; bus1.req1_src = 0; bus1.req1_dst = 0; bus1.req1_imm = 0;
    bus2.req0_mode = 0; bus2.req0_src = 0; bus2.req0_dst = 0; bus2.req0_imm = 0;
    bus2.req1_mode = 0; bus2.req1_src = 0; bus2.req1_dst = 0; bus2.req1_imm = 0;
    for (int i = 0; i < 16; i++) ram[i] = 16'h0;

    repeat (2) @(negedge clk);
    check("reset_enables", {29'd0, bus1.read_en, bus1.write_en, bus1.data_out_en}, 32'd0);
    check("reset_rsp", {15'd0, bus1.rsp_valid, bus1.rsp_id, bus1.rsp_data}, 32'd0);
    check("reset_addr", {bus1.read_addr, bus1.write_addr}, 32'd0);
    check("reset_ready", {30'd0, bus1.req0_ready, bus1.req1_ready}, 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;

    // Immediate write of 5 to ALU_1
    send(1'b0, 2'b10, 16'h0, ALU_1, 16'd5, 16'h0, 2, 1'b1);
    @(negedge clk);
    check("imm_write_en", 32'(bus1.write_en), 32'd1);
    check("imm_write_addr", 32'(bus1.write_addr), 32'(ALU_1));
    check("imm_data_out", 32'(bus1.data_out), 32'd5);
    check("imm_data_out_en", 32'(bus1.data_out_en), 32'd1);
    check("imm_read_en", 32'(bus1.read_en), 32'd0);
    drain();

    send(1'b1, 2'b10, 16'h0, ALU_2, 16'd3, 16'h0, 2, 1'b1);
    drain();

    // Read of the ALU sum by the debug port
    send(1'b1, 2'b01, ALU_ADD, 16'h0, 16'h0, 16'd8, 2, 1'b1);
    @(negedge clk);
    check("read_en_on", 32'(bus1.read_en), 32'd1);
    check("read_addr", 32'(bus1.read_addr), 32'(ALU_ADD));
    check("read_no_write", 32'(bus1.write_en), 32'd0);
    @(negedge clk);
    check("read_en_off", 32'(bus1.read_en), 32'd0);
    drain();

    // Move RAM_START -> RAM_START+1
    send(1'b0, 2'b10, 16'h0, RAM_START, 16'habcd, 16'h0, 2, 1'b1);
    drain();
    send(1'b0, 2'b11, RAM_START, RAM_START + 16'd1, 16'h0, 16'habcd, 3, 1'b1);
    @(negedge clk);
    check("move_read_en", 32'(bus1.read_en), 32'd1);
    check("move_read_no_wr", 32'(bus1.write_en), 32'd0);
    @(negedge clk);
    check("move_wr_phase", {29'd0, bus1.read_en, bus1.write_en, bus1.data_out_en}, 32'b110);
    check("move_addrs", {bus1.read_addr, bus1.write_addr}, {RAM_START, RAM_START + 16'd1});
    drain();
    send(1'b1, 2'b01, RAM_START + 16'd1, 16'h0, 16'h0, 16'habcd, 2, 1'b1);
    drain();

    // Round robin with both requesters holding no-op descriptors
    bus1.req0_mode = 2'b00; bus1.req1_mode = 2'b00;
    bus1.req0_valid = 1'b1; bus1.req1_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk);
        got = bus1.req0_ready | bus1.req1_ready;
      end
      check("rr_any_grant", 32'(got), 32'd1);
      check("rr_order", 32'(bus1.req1_ready), 32'(k % 2));
      if (got) push1(1'(k % 2), 16'h0, 1);
      @(posedge clk); #1;
    end
    bus1.req0_valid = 1'b0; bus1.req1_valid = 1'b0;
    drain();

    // Lone req0 is granted every 2 cycles
    bus1.req0_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk);
        got = bus1.req0_ready;
      end
      acc[k] = cyc;
      check("b2b_grant", 32'(got), 32'd1);
      if (got) push1(1'b0, 16'h0, 1);
      @(posedge clk); #1;
    end
    bus1.req0_valid = 1'b0;
    check("b2b_gap1", 32'(acc[1] - acc[0]), 32'd2);
    check("b2b_gap2", 32'(acc[2] - acc[1]), 32'd2);
    drain();

    // enable low blocks grants; raising it grants in that cycle
    bus1.enable = 1'b0;
    bus1.req0_mode = 2'b01; bus1.req0_src = ALU_ADD; bus1.req0_valid = 1'b1;
    stuck = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus1.req0_ready) stuck++;
    end
    check("disabled_no_ready", 32'(stuck), 32'd0);
    @(posedge clk); #1 bus1.enable = 1'b1;
    @(negedge clk);
    check("enable_ready", 32'(bus1.req0_ready), 32'd1);
    if (bus1.req0_ready) push1(1'b0, 16'd8, 2);
    @(posedge clk); #1 bus1.req0_valid = 1'b0;
    drain();

    // Reset during the READ of a move abandons it
    send(1'b0, 2'b11, RAM_START, RAM_START + 16'd2, 16'h0, 16'h0, 3, 1'b0);
    @(negedge clk);
    check("abort_read_en_pre", 32'(bus1.read_en), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("abort_enables", {30'd0, bus1.read_en, bus1.write_en}, 32'd0);
    check("abort_rsp", 32'(bus1.rsp_valid), 32'd0);
    bus1.req0_mode = 2'b00; bus1.req1_mode = 2'b00;
    bus1.req0_valid = 1'b1; bus1.req1_valid = 1'b1;
    @(negedge clk);
    check("reset_blocks_ready", {30'd0, bus1.req0_ready, bus1.req1_ready}, 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("post_reset_grant", {30'd0, bus1.req0_ready, bus1.req1_ready}, 32'b10);
    if (bus1.req0_ready) push1(1'b0, 16'h0, 1);
    @(posedge clk); #1;
    bus1.req0_valid = 1'b0; bus1.req1_valid = 1'b0;
    drain();
    check("abort_no_write", 32'(ram[2]), 32'd0);

    // READ_WAIT=2 instance: three read cycles, capture only in the third
    bus2.req1_mode = 2'b01; bus2.req1_src = ALU_ADD; bus2.req1_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = bus2.req1_ready;
    end
    check("slow_accept", 32'(got), 32'd1);
    if (got) begin
      exp_t e;
      e.id = 1'b1; e.data = 16'd8; e.due = cyc + 4;
      q2.push_back(e);
    end
    @(posedge clk); #1 bus2.req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("slow_read_en", 32'(bus2.read_en), 32'(i < 3));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the three-bus fabric (read_bus, data_bus, write_bus) between two bus masters: req0 is the control unit and req1 is the debug/loader port.
- Each master submits one transfer descriptor. The block grants descriptors round-robin, then sequences the read and write phases of the granted transfer.
- It drives the bus address and enable lines, captures read data off data_bus, and returns a completion response.
- It sits between the masters and the alu/ram/rom bus slaves.

Parameters:
- ADDR_WIDTH, 16, width of read_bus/write_bus addresses
- DATA_WIDTH, 16, width of data_bus
- READ_WAIT, 0, extra READ cycles inserted for slow slaves (0..7)

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  when low, no new grants; an in-flight transfer still completes
- reqN_valid  in  1  (N=0,1) descriptor valid
- reqN_ready  out  1  one-cycle accept pulse
- reqN_mode  in  2  bit0 = src_en (read phase), bit1 = dst_en (write phase)
- reqN_src  in  ADDR_WIDTH  read address
- reqN_dst  in  ADDR_WIDTH  write address
- reqN_imm  in  DATA_WIDTH  immediate data; driven when dst_en=1 and src_en=0
- read_addr  out  ADDR_WIDTH  read_bus value
- read_en  out  1  read_bus drive enable
- write_addr  out  ADDR_WIDTH  write_bus value
- write_en  out  1  write_bus drive enable (write strobe)
- data_out  out  DATA_WIDTH  data_bus value from the arbiter
- data_out_en  out  1  data_bus drive enable
- data_in  in  DATA_WIDTH  data_bus sampled value
- rsp_valid  out  1  one-cycle completion pulse
- rsp_id  out  1  requester that completed
- rsp_data  out  DATA_WIDTH  data captured in the last READ cycle; 0 if no read phase

Behaviour:
- Reset (asynchronous, active-low):
  - State = IDLE; last_grant = 1, so req0 wins the first tie.
  - All outputs 0, including every enable, address, rsp_* signal and both ready pulses.
  - Reset asserted mid-transfer abandons the transfer immediately. No response is issued and bus enables drop in the same instant.
- States: IDLE, READ, WRITE, RESP.
- IDLE arbitration:
  - Arbitration runs when enable=1 and at least one reqN_valid=1.
  - A single valid requester is granted.
  - If both are valid, the grant goes to the requester other than last_grant.
  - reqN_ready is asserted combinationally in that cycle. The descriptor, id and last_grant are latched at the clock edge.
- Next state from IDLE on grant: READ if src_en=1; else WRITE if dst_en=1; else RESP (mode 00 is a no-op).
- READ state:
  - Outputs: read_en=1, read_addr=src.
  - The phase lasts 1+READ_WAIT cycles, counted by a wait counter.
  - data_in is captured into rsp_data at the edge ending the final READ cycle.
  - Next state: WRITE if dst_en=1, else RESP.
- WRITE state (exactly 1 cycle):
  - write_en=1, write_addr=dst.
  - If src_en=1 (move): read_en stays 1 with the same read_addr, so the source slave keeps driving data_bus; data_out_en=0.
  - If src_en=0: data_out=imm, data_out_en=1.
  - Next state: RESP.
- RESP state (1 cycle): rsp_valid=1 with rsp_id and rsp_data; next state IDLE. No grant is issued in RESP.
- Latency from the accept cycle to the rsp_valid cycle, with READ_WAIT=0:
  - move (mode 11): 3 cycles
  - read-only (mode 01): 2 cycles
  - immediate write (mode 10): 2 cycles
  - no-op (mode 00): 1 cycle
- Each extra READ_WAIT adds one cycle to any mode with a read phase.
- Handshake rules:
  - Only one outstanding transfer exists at a time.
  - A requester must hold valid and its descriptor stable until ready.
  - The arbiter samples the descriptor only in the accept cycle; later changes are ignored.
- Bus exclusivity:
  - data_out_en and a move's read_en are never both asserted with write_en.
  - read_en, write_en and data_out_en are 0 in IDLE and RESP.
- enable falling mid-transfer has no effect until the next IDLE. enable=0 in IDLE blocks all grants, and valids stay pending.
- Address and data outputs hold their last value when the enables are 0. They are don't-care and are checked only while enabled.

Test Plan:
- Immediate write: req0 mode=10, dst=`ALU_1, imm=5.
  - ready0 in cycle 0; WRITE in cycle 1 with write_en=1, write_addr=`ALU_1, data_out=5, data_out_en=1.
  - rsp_valid in cycle 2, rsp_id=0, rsp_data=0.
- Read: after writing 5 to ALU_1 and 3 to ALU_2, req1 mode=01, src=`ALU_ADD.
  - read_en held 1 cycle.
  - rsp_valid with rsp_id=1, rsp_data=8.
- Move: req0 mode=11, src=`RAM_START+0 (pre-loaded 0xabcd), dst=`RAM_START+1.
  - READ cycle, then WRITE cycle with read_en=1 and write_en=1 together, data_out_en=0.
  - rsp_data=0xabcd; a subsequent read of RAM_START+1 returns 0xabcd.
- Round-robin: req0 and req1 both held valid with mode=00 for 6 transfers.
  - Grant order is 0,1,0,1,0,1.
  - With only req0 valid, it is granted back-to-back every 2 cycles.
- READ_WAIT=2, read of `ALU_ADD: read_en held 3 cycles; data captured only in the 3rd cycle; rsp_valid 4 cycles after accept.
- Control and reset:
  - enable=0 with req0 valid: no ready for 10 cycles. Raising enable gives ready next cycle.
  - Reset pulled low during the READ of a move: read_en/write_en drop immediately, no rsp_valid, state returns to IDLE, and the next grant goes to req0 first.
